// File: rtl/simon_pkg.sv
// simon_pkg: color codes and input-arbiter state encoding shared with the game FSM
package simon_pkg;
  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] GREEN  = 2'b01;
  localparam logic [1:0] BLUE   = 2'b10;
  localparam logic [1:0] YELLOW = 2'b11;
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SETTLE  = 2'b01,
    VALID   = 2'b10,
    RELEASE = 2'b11
  } arb_state_t;
endpackage

// File: rtl/simon_tick_gen.sv
// simon_tick_gen: free-running divider producing a one-cycle tick every TICK_MAX clocks
module simon_tick_gen #(
  parameter int TICK_MAX = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int TW = $clog2(TICK_MAX);
  logic [TW-1:0] cnt;
  assign tick = cnt == TW'(TICK_MAX - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/simon_input_arbiter.sv
// simon_input_arbiter: debounces the color buttons and hands one color code per press to the game FSM
module simon_input_arbiter
  import simon_pkg::*;
#(
  parameter int N_BTN     = 4,
  parameter int CODE_BITS = 2,
  parameter int TICK_MAX  = 50000,
  parameter int DEB_TICKS = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_BTN-1:0]     btn,
  input  logic                 enable,
  input  logic                 code_ready,
  output logic [CODE_BITS-1:0] code,
  output logic                 code_valid,
  output logic                 conflict,
  output logic                 busy
);
  localparam int CW = $clog2(DEB_TICKS + 1);
  localparam int PW = $clog2(N_BTN + 1);
  arb_state_t state, state_n;
  logic [N_BTN-1:0] s1, bs, cand, cand_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CODE_BITS-1:0] code_n, idx;
  logic [PW-1:0] pop;
  logic tick, conflict_n, single, multi;
  simon_tick_gen #(.TICK_MAX(TICK_MAX)) u_tick (.clk(clk), .reset(reset), .tick(tick));
  always_comb begin
    pop = '0;
    idx = '0;
    for (int i = 0; i < N_BTN; i++) begin
      pop = pop + PW'(bs[i]);
      if (cand[i]) idx = CODE_BITS'(i);
    end
  end
  assign single     = pop == PW'(1);
  assign multi      = pop > PW'(1);
  assign code_valid = state == VALID;
  assign busy       = state != IDLE;
  always_comb begin
    state_n    = state;
    cand_n     = cand;
    cnt_n      = cnt;
    code_n     = code;
    conflict_n = 1'b0;
    case (state)
      IDLE:
        if (enable && multi) begin
          conflict_n = 1'b1;
          cnt_n      = '0;
          state_n    = RELEASE;
        end else if (enable && single) begin
          cand_n  = bs;
          cnt_n   = '0;
          state_n = SETTLE;
        end
      SETTLE:
        if (multi) begin
          conflict_n = 1'b1;
          cnt_n      = '0;
          state_n    = RELEASE;
        end else if (bs != cand || !enable) state_n = IDLE;
        else if (tick) begin
          cnt_n = cnt + 1'b1;
          if (cnt_n == CW'(DEB_TICKS)) begin
            code_n  = idx;
            state_n = VALID;
          end
        end
      VALID:
        if (code_ready) begin
          cnt_n   = '0;
          state_n = RELEASE;
        end
      default:
        if (|bs) cnt_n = '0;
        else if (tick) begin
          cnt_n = cnt + 1'b1;
          if (cnt_n == CW'(DEB_TICKS)) state_n = IDLE;
        end
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1       <= '0;
      bs       <= '0;
      state    <= IDLE;
      cand     <= '0;
      cnt      <= '0;
      code     <= '0;
      conflict <= 1'b0;
    end else begin
      s1       <= btn;
      bs       <= s1;
      state    <= state_n;
      cand     <= cand_n;
      cnt      <= cnt_n;
      code     <= code_n;
      conflict <= conflict_n;
    end
endmodule

// File: tb/tb_simon_input_arbiter.sv
// tb_simon_input_arbiter: scoreboard bench with press-level reference model and random scenarios
module tb_simon_input_arbiter;
  localparam int TM = 4, DT = 3;
  logic clk = 0, reset = 1, enable = 0, code_ready = 0;
  logic [3:0] btn = '0;
  logic [1:0] code;
  logic code_valid, conflict, busy;
  int n_chk = 0, n_fail = 0;
  bit rnd_rdy = 0;
  typedef struct {bit conf; logic [1:0] code;} ev_t;
  ev_t exp_q[$];
  ev_t e;
  logic prev_wait = 0;
  logic [1:0] prev_code = '0;

  simon_input_arbiter #(.N_BTN(4), .CODE_BITS(2), .TICK_MAX(TM), .DEB_TICKS(DT)) dut (
    .clk(clk), .reset(reset), .btn(btn), .enable(enable), .code_ready(code_ready),
    .code(code), .code_valid(code_valid), .conflict(conflict), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_rdy) code_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push_code(int c);
    ev_t t;
    t.conf = 0;
    t.code = 2'(c);
    exp_q.push_back(t);
  endtask

  task automatic push_conflict();
    ev_t t;
    t.conf = 1;
    t.code = '0;
    exp_q.push_back(t);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 400) begin
      step();
      k++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  task automatic wait_valid(string nm);
    int k = 0;
    while (!code_valid && k < 40) begin
      step();
      k++;
    end
    chk(nm, int'(code_valid), 1);
  endtask

  // Press-level model: a lone button held past the debounce window yields its index,
  // several buttons at once yield a conflict, anything shorter or disabled yields nothing.
  task automatic press(logic [3:0] vec, int hold, bit en);
    enable = en;
    if (en && $countones(vec) > 1) push_conflict();
    else if (en && $countones(vec) == 1 && hold >= 20)
      for (int i = 0; i < 4; i++) if (vec[i]) push_code(i);
    btn = vec;
    repeat (hold) step();
    btn = '0;
    repeat (3) step();
    wait_idle();
    step();
  endtask

  always @(negedge clk) begin
    if (reset) prev_wait <= 0;
    else begin
      if (prev_wait) begin
        chk("valid_withdrawn", int'(code_valid), 1);
        chk("code_unstable", int'(code), int'(prev_code));
      end
      if (conflict || (code_valid && code_ready)) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_event: got conflict=%0d code=%0d expected none", conflict, code);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", int'(conflict), int'(e.conf));
          if (!e.conf) chk("event_code", int'(code), int'(e.code));
        end
      end
      prev_wait <= code_valid && !code_ready;
      prev_code <= code;
    end
  end

  initial begin
    int lat;
    int kind;
    logic [3:0] v;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(code_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_conflict", int'(conflict), 0);
    chk("rst_code", int'(code), 0);
    reset = 0;
    step();
    // clean press
    enable = 1;
    code_ready = 1;
    btn = 4'b0100;
    push_code(2);
    lat = 0;
    while (!code_valid && lat < 40) begin
      step();
      lat++;
    end
    chk("clean_latency_12_16", int'(lat >= 12 && lat <= 16), 1);
    step();
    chk("clean_one_cycle", int'(code_valid), 0);
    repeat (30) step();
    btn = '0;
    repeat (3) step();
    wait_idle();
    // bounce
    for (int i = 0; i < 7; i++) begin
      btn[1] = ~btn[1];
      repeat (3) step();
    end
    push_code(1);
    repeat (25) step();
    btn = '0;
    repeat (3) step();
    wait_idle();
    // conflict
    btn = 4'b1001;
    push_conflict();
    repeat (20) step();
    chk("conflict_busy_release", int'(busy), 1);
    btn = '0;
    repeat (14) step();
    wait_idle();
    btn = 4'b0001;
    push_code(0);
    repeat (25) step();
    btn = '0;
    repeat (3) step();
    wait_idle();
    // backpressure
    code_ready = 0;
    btn = 4'b1000;
    push_code(3);
    wait_valid("bp_valid_seen");
    enable = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      chk("bp_valid_held", int'(code_valid), 1);
      chk("bp_code", int'(code), 3);
    end
    code_ready = 1;
    step();
    chk("bp_after_xfer", int'(code_valid), 0);
    chk("bp_busy_release", int'(busy), 1);
    btn = '0;
    enable = 1;
    repeat (3) step();
    wait_idle();
    // disabled
    enable = 0;
    btn = 4'b0010;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("dis_busy", int'(busy), 0);
      chk("dis_valid", int'(code_valid), 0);
    end
    btn = '0;
    repeat (3) step();
    enable = 1;
    // reset while VALID
    code_ready = 0;
    btn = 4'b0100;
    wait_valid("rstmid_valid_seen");
    #2;
    reset = 1;
    #1;
    chk("rstmid_valid", int'(code_valid), 0);
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_code", int'(code), 0);
    step();
    step();
    reset = 0;
    push_code(2);
    code_ready = 1;
    wait_valid("rstmid_redeliver");
    step();
    btn = '0;
    repeat (3) step();
    wait_idle();
    // randomized scenarios
    rnd_rdy = 1;
    for (int n = 0; n < 25; n++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: press(4'b0001 << $urandom_range(0, 3), $urandom_range(20, 30), 1);
        1: press(4'b0001 << $urandom_range(0, 3), $urandom_range(1, 6), 1);
        2: begin
          do v = 4'($urandom_range(1, 15)); while ($countones(v) < 2);
          press(v, $urandom_range(1, 30), 1);
        end
        default: press(4'($urandom_range(1, 15)), $urandom_range(20, 30), 0);
      endcase
    end
    rnd_rdy = 0;
    code_ready = 1;
    enable = 1;
    repeat (5) step();
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/simon_input_arbiter.md
Name: simon_input_arbiter

Overview:
- Arbitrates the four raw color push-buttons of the Simon game into a single debounced color code, delivered with a valid/ready handshake to the game FSM.
- Sits between the board pins and the game FSM's color input.
- Rejects simultaneous presses, enforces press/release debouncing, and accepts input only while the game is in its input phase.

Parameters:
- N_BTN, 4, number of color buttons. Button i maps to code i: 0 RED, 1 GREEN, 2 BLUE, 3 YELLOW.
- CODE_BITS, 2, width of the color code; must satisfy 2**CODE_BITS >= N_BTN.
- TICK_MAX, 50000, clk cycles per debounce tick (1 ms at 50 MHz).
- DEB_TICKS, 20, number of consecutive stable ticks required to accept a press or a release.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous active-high reset.
- btn, in, N_BTN, raw active-high buttons, asynchronous to clk.
- enable, in, 1, game FSM is in its input phase; new presses are only captured while high.
- code_ready, in, 1, consumer accepts code this cycle.
- code, out, CODE_BITS, index of the pressed button.
- code_valid, out, 1, code is available.
- conflict, out, 1, one-cycle pulse when more than one button is seen pressed.
- busy, out, 1, high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, any state, mid-handshake included):
  - state=IDLE; code=0, code_valid=0, conflict=0, busy=0.
  - Synchronizer flops, tick counter and settle counter all cleared.
- Synchronizer: btn passes through 2 flops to give bs. All decisions use bs, so there are 2 cycles of latency.
- Tick generator: free-running counter 0..TICK_MAX-1. tick=1 for one cycle when the counter equals TICK_MAX-1, then it wraps to 0.
- FSM states: IDLE, SETTLE, VALID, RELEASE.
- IDLE:
  - enable=1 and popcount(bs)==1: latch the vector into cand; clear settle_cnt; go to SETTLE.
  - enable=1 and popcount(bs)>1: conflict=1 for one cycle; go to RELEASE.
  - enable=0: stay in IDLE and ignore bs.
- SETTLE:
  - bs!=cand, or enable=0: return to IDLE with no output.
  - popcount(bs)>1: pulse conflict and go to RELEASE. This check takes precedence over the bs!=cand check.
  - On tick with bs==cand: settle_cnt+1. When settle_cnt reaches DEB_TICKS, load code=index(cand), set code_valid=1 on the next clk edge, and go to VALID.
- VALID:
  - code_valid=1 and code is held stable until a cycle with code_valid&code_ready.
  - Transfer occurs in that cycle. The next cycle has code_valid=0 and state=RELEASE.
  - enable falling does NOT withdraw code_valid; once asserted it must complete the transfer.
  - Button activity is ignored while in VALID.
- RELEASE:
  - Requires bs==0 stable for DEB_TICKS ticks. settle_cnt is cleared whenever bs!=0.
  - After DEB_TICKS stable ticks, go to IDLE.
  - Holding a button never produces a second code.
- Latency: from the btn edge to code_valid, between 2+1+(DEB_TICKS-1)*TICK_MAX+1 and 2+1+DEB_TICKS*TICK_MAX+1 cycles, depending on tick phase.
- Widths: settle_cnt is $clog2(DEB_TICKS+1) bits. The tick counter is $clog2(TICK_MAX) bits. popcount is computed combinationally over N_BTN bits.
- conflict is never asserted in the same cycle as a code_valid rising edge.

Decomposition:
- Shared package simon_pkg:
  - Color code constants RED/GREEN/BLUE/YELLOW (2'b00..2'b11), shared with the game FSM.
  - Arbiter state encoding: IDLE=2'b00, SETTLE=2'b01, VALID=2'b10, RELEASE=2'b11.
- One sub-module, simon_tick_gen: parameter TICK_MAX, ports clk/reset/tick.
- The synchronizer, popcount and FSM stay inline.

Test Plan (TICK_MAX=4, DEB_TICKS=3):
- Clean press: hold btn=4'b0100, enable=1, code_ready=1. code_valid pulses for exactly 1 cycle with code=2'd2, 12-16 cycles after the edge. No further code_valid while the button is held.
- Bounce: toggle btn[1] every 3 cycles for 20 cycles, then hold it. No code_valid during bouncing; afterwards exactly one code=2'd1.
- Conflict: btn=4'b1001 held. conflict=1 for exactly 1 cycle and code_valid stays 0. After release (0 for ≥12 cycles) followed by btn=4'b0001, code=2'd0 is delivered.
- Backpressure: press btn[3] with code_ready=0 for 30 cycles, dropping enable meanwhile. code_valid stays 1 with code=2'd3 throughout. Raising code_ready gives a 1-cycle transfer, then RELEASE.
- Disabled: enable=0 with btn=4'b0010 held for 50 cycles. code_valid=0, conflict=0, busy=0.
- Reset mid-operation: assert reset while in VALID (code_valid=1). In the same cycle, code_valid=0, busy=0, code=0 asynchronously. After deassert with the button still held, the FSM starts a fresh SETTLE and delivers the code again.
